sum_block_accum: RTL and testbench
==================================

Name: sum_block_accum

Overview:
Downstream consumer of the registered adder stage. Takes the registered sum and zero flag every qualified cycle and accumulates BLOCK_LEN sums into a block total, counting zero results. It queues completed blocks in a small FIFO and releases them on a valid/ready output. The adder side has no backpressure, so input is never stalled; overflow is reported instead.

Parameters:
SWIDTH, 33, width of incoming sum (adder WIDTH+1)
ACC_WIDTH, 36, width of block accumulator (must be >= SWIDTH)
BLOCK_LEN, 8, samples per block (>= 1)
DEPTH, 4, output FIFO entries (power of two, >= 2)
CNT_WIDTH, $clog2(BLOCK_LEN+1), width of zero counter and sample counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear of partial block and overflow flag
in_valid  input  1  in_sum/in_zero qualify this cycle
in_sum  input  SWIDTH  registered sum from adder stage
in_zero  input  1  registered zero flag from adder stage
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_sum  output  ACC_WIDTH  block total (saturated)
out_zero_cnt  output  CNT_WIDTH  number of in_zero=1 samples in block
out_sat  output  1  block total saturated
ovf  output  1  sticky: a completed block was dropped (FIFO full)
fill  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_n=0, async): accumulator=0, sample count=0, zero count=0, sat=0, FIFO empty; out_valid=0, out_sum=0, out_zero_cnt=0, out_sat=0, ovf=0, fill=0.
- Accept: sample consumed on every rising clk with in_valid=1 and clr=0; no ready on input side.
- Accumulate: acc_next = acc + zero-extended in_sum; if the true sum exceeds 2^ACC_WIDTH-1, acc_next = all ones and the block sat bit is set. Once saturated, the accumulator stays all ones for the rest of the block.
- Zero count increments when in_zero=1 on an accepted sample. in_zero is used as given and is not recomputed from in_sum.
- Block completion: the accepted sample that brings the sample count to BLOCK_LEN completes the block.
  - On that edge, {acc_next, zcnt_next, sat_next} is pushed to the FIFO.
  - Accumulator, counts and sat return to 0 on the same edge; the next sample starts a fresh block with no gap cycle.
- BLOCK_LEN=1: every accepted sample is its own block.
- FIFO: registered, DEPTH entries, first-in first-out.
  - out_* show the head entry whenever out_valid=1; pop on out_valid & out_ready.
  - An entry pushed at edge N is visible (out_valid=1) after edge N, i.e. in cycle N+1.
  - out_sum/out_zero_cnt/out_sat hold their last values when empty; out_valid=0 when empty.
  - out_* stable while out_valid=1 and out_ready=0.
- Full: push succeeds if fill<DEPTH or a pop occurs on the same edge, in which case fill is unchanged.
  - Otherwise the block is dropped, ovf is set (sticky), and accumulator/counters still clear.
- Simultaneous push and pop on empty FIFO: push wins; fill becomes 1.
- Pointer wrap: read/write pointers wrap modulo DEPTH; fill disambiguates full from empty.
- clr=1: clears accumulator, sample count, zero count, sat and ovf on that edge.
  - An in_valid sample in the same cycle is discarded.
  - FIFO contents and pop behaviour are unaffected.
- Reset mid-block or with FIFO occupied discards everything; the first post-reset sample starts a new block.

Test Plan:
- Basic block: after reset, 8 samples of in_sum=10 with in_zero=0 on consecutive cycles -> one cycle after the 8th edge, out_valid=1, out_sum=80, out_zero_cnt=0, out_sat=0, fill=1.
- Zero counting plus gaps: samples 0,5,0,0,7,0,1,2 with in_valid toggling 1/0 and in_zero set where in_sum=0 -> out_sum=15, out_zero_cnt=4; no entry before the 8th accepted sample.
- Saturation (ACC_WIDTH=34): 8 samples of 2^33-1 -> out_sum=2^34-1, out_sat=1; the next block of 8x1 gives out_sum=8, out_sat=0.
- Backpressure/overflow (DEPTH=4, out_ready=0): 5 blocks of 8x1 -> fill=4, ovf=1 after the 5th block. Then out_ready=1 -> four entries of out_sum=8 drained in order, fill=0; ovf stays 1 until clr.
- Push with pop at full: FIFO full and out_ready=1 on the edge a block completes -> no drop, ovf=0, fill stays 4, new total appears after three more pops.
- clr mid-block: 3 samples of 100, then clr=1 with in_valid=1 and in_sum=100, then 8 samples of 2 -> single entry out_sum=16, out_zero_cnt=0, ovf=0. Async rst_n pulse mid-block -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/sum_block_accum.sv
// Block accumulator behind the registered adder stage: sums BLOCK_LEN samples,
// counts zero flags, and queues completed blocks in a small valid/ready FIFO.
module sum_block_accum #(
   parameter int unsigned SWIDTH    = 33,
   parameter int unsigned ACC_WIDTH = 36,
   parameter int unsigned BLOCK_LEN = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CNT_WIDTH = $clog2(BLOCK_LEN + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         in_valid,
   input  logic [SWIDTH-1:0]            in_sum,
   input  logic                         in_zero,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_WIDTH-1:0]         out_sum,
   output logic [CNT_WIDTH-1:0]         out_zero_cnt,
   output logic                         out_sat,
   output logic                         ovf,
   output logic [$clog2(DEPTH+1)-1:0]   fill
);

   localparam int unsigned FILL_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned EXT_W  = ACC_WIDTH + 1;

   typedef struct packed {
      logic [ACC_WIDTH-1:0] sum;
      logic [CNT_WIDTH-1:0] zcnt;
      logic                 sat;
   } entry_t;

   logic [ACC_WIDTH-1:0] r_acc;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_zcnt;
   logic                 r_sat;
   logic                 r_ovf;
   entry_t               r_mem [DEPTH];
   logic [PTR_W-1:0]     r_wr;
   logic [PTR_W-1:0]     r_rd;
   logic [FILL_W-1:0]    r_fill;
   logic                 r_valid;
   entry_t               r_head;

   logic                 w_accept;
   logic [EXT_W-1:0]     w_ext;
   logic                 w_sat_next;
   logic [ACC_WIDTH-1:0] w_acc_next;
   logic [CNT_WIDTH-1:0] w_zcnt_next;
   logic [CNT_WIDTH-1:0] w_cnt_next;
   logic                 w_done;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   entry_t               w_new;
   logic [PTR_W-1:0]     w_rd_next;
   logic [FILL_W-1:0]    w_fill_next;
   entry_t               w_head_next;

   // Saturating accumulate; the carry bit of the widened sum flags overflow.
   assign w_accept    = in_valid & ~clr;
   assign w_ext       = EXT_W'(r_acc) + EXT_W'(in_sum);
   assign w_sat_next  = r_sat | w_ext[ACC_WIDTH];
   assign w_acc_next  = w_sat_next ? '1 : w_ext[ACC_WIDTH-1:0];
   assign w_zcnt_next = r_zcnt + CNT_WIDTH'(in_zero);
   assign w_cnt_next  = r_cnt + CNT_WIDTH'(1);
   assign w_done      = w_accept & (w_cnt_next == CNT_WIDTH'(BLOCK_LEN));

   assign w_pop  = r_valid & out_ready;
   assign w_push = w_done & ((r_fill != FILL_W'(DEPTH)) | w_pop);
   assign w_drop = w_done & ~w_push;
   assign w_new  = '{sum: w_acc_next, zcnt: w_zcnt_next, sat: w_sat_next};

   // Next head: the incoming block if it lands at the read slot, else the stored entry.
   always_comb begin
      w_rd_next   = r_rd;
      w_fill_next = r_fill;
      w_head_next = r_head;
      if (w_pop)
         w_rd_next = r_rd + PTR_W'(1);
      if (w_push && !w_pop)
         w_fill_next = r_fill + FILL_W'(1);
      else if (!w_push && w_pop)
         w_fill_next = r_fill - FILL_W'(1);
      if (w_fill_next != '0) begin
         if (w_push && (r_fill == FILL_W'(w_pop)))
            w_head_next = w_new;
         else
            w_head_next = r_mem[w_rd_next];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_zcnt <= '0;
         r_sat  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (clr) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_zcnt <= '0;
         r_sat  <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_done) begin
               r_acc  <= '0;
               r_cnt  <= '0;
               r_zcnt <= '0;
               r_sat  <= 1'b0;
            end else begin
               r_acc  <= w_acc_next;
               r_cnt  <= w_cnt_next;
               r_zcnt <= w_zcnt_next;
               r_sat  <= w_sat_next;
            end
         end
         if (w_drop)
            r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr] <= w_new;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_fill  <= '0;
         r_valid <= 1'b0;
         r_head  <= '0;
      end else begin
         if (w_push)
            r_wr <= r_wr + PTR_W'(1);
         r_rd    <= w_rd_next;
         r_fill  <= w_fill_next;
         r_valid <= (w_fill_next != '0);
         r_head  <= w_head_next;
      end
   end

   assign out_valid    = r_valid;
   assign out_sum      = r_head.sum;
   assign out_zero_cnt = r_head.zcnt;
   assign out_sat      = r_head.sat;
   assign ovf          = r_ovf;
   assign fill         = r_fill;

endmodule

// File: tb/tb_sum_block_accum.sv
// Directed bench for sum_block_accum: block table plus overflow, full-push-pop,
// clear and async-reset sequences.
module tb_sum_block_accum;

   localparam int unsigned SW = 33;
   localparam int unsigned AW = 34;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic          in_valid;
   logic [SW-1:0] in_sum;
   logic          in_zero;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic [CW-1:0] out_zero_cnt;
   logic          out_sat;
   logic          ovf;
   logic [2:0]    fill;

   int n_vec = 0;
   int n_err = 0;

   sum_block_accum #(.SWIDTH(SW), .ACC_WIDTH(AW), .BLOCK_LEN(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_sum(in_sum),
      .in_zero(in_zero), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_zero_cnt(out_zero_cnt), .out_sat(out_sat),
      .ovf(ovf), .fill(fill)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0][SW-1:0] samp;
      logic [7:0]         zmask;
      logic               gaps;
      logic [AW-1:0]      exp_sum;
      logic [CW-1:0]      exp_zc;
      logic               exp_sat;
   } blk_t;

   blk_t tbl [4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [SW-1:0] s, input logic z);
      in_valid = 1'b1;
      in_sum   = s;
      in_zero  = z;
      tick();
      in_valid = 1'b0;
      in_zero  = 1'b0;
   endtask

   task automatic send_block(input logic [SW-1:0] s);
      for (int i = 0; i < 8; i++) send(s, 1'b0);
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      tbl[0].samp = {8{33'd10}};
      tbl[0].zmask = 8'h00; tbl[0].gaps = 1'b0;
      tbl[0].exp_sum = 34'd80; tbl[0].exp_zc = 4'd0; tbl[0].exp_sat = 1'b0;
      tbl[1].samp = {33'd2, 33'd1, 33'd0, 33'd7, 33'd0, 33'd0, 33'd5, 33'd0};
      tbl[1].zmask = 8'b0010_1101; tbl[1].gaps = 1'b1;
      tbl[1].exp_sum = 34'd15; tbl[1].exp_zc = 4'd4; tbl[1].exp_sat = 1'b0;
      tbl[2].samp = {8{33'h1_FFFF_FFFF}};
      tbl[2].zmask = 8'h00; tbl[2].gaps = 1'b0;
      tbl[2].exp_sum = 34'h3_FFFF_FFFF; tbl[2].exp_zc = 4'd0; tbl[2].exp_sat = 1'b1;
      tbl[3].samp = {8{33'd1}};
      tbl[3].zmask = 8'h00; tbl[3].gaps = 1'b0;
      tbl[3].exp_sum = 34'd8; tbl[3].exp_zc = 4'd0; tbl[3].exp_sat = 1'b0;

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sum = '0; in_zero = 1'b0;
      out_ready = 1'b0;
      tick(); tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(out_sum), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_fill", 64'(fill), 64'd0);
      rst_n = 1'b1;
      tick();

      // Table of single blocks, each checked at the head then popped.
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            send(tbl[b].samp[i], tbl[b].zmask[i]);
            if (tbl[b].gaps) tick();
            if (i == 6) chk($sformatf("blk%0d_early", b), 64'(out_valid), 64'd0);
         end
         chk($sformatf("blk%0d_valid", b), 64'(out_valid), 64'd1);
         chk($sformatf("blk%0d_sum", b), 64'(out_sum), 64'(tbl[b].exp_sum));
         chk($sformatf("blk%0d_zc", b), 64'(out_zero_cnt), 64'(tbl[b].exp_zc));
         chk($sformatf("blk%0d_sat", b), 64'(out_sat), 64'(tbl[b].exp_sat));
         chk($sformatf("blk%0d_fill", b), 64'(fill), 64'd1);
         pop_one();
         chk($sformatf("blk%0d_popfill", b), 64'(fill), 64'd0);
         chk($sformatf("blk%0d_hold", b), 64'(out_sum), 64'(tbl[b].exp_sum));
      end

      // Overflow: five blocks into a four-deep FIFO with no consumer.
      for (int k = 1; k <= 5; k++) begin
         send_block(SW'(k));
         if (k == 4) begin
            chk("ovf_fill4", 64'(fill), 64'd4);
            chk("ovf_before", 64'(ovf), 64'd0);
         end
      end
      chk("ovf_fill5", 64'(fill), 64'd4);
      chk("ovf_set", 64'(ovf), 64'd1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("drain%0d_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("drain%0d_sum", k), 64'(out_sum), 64'(8 * k));
         tick();
      end
      out_ready = 1'b0;
      chk("drain_fill", 64'(fill), 64'd0);
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("ovf_sticky", 64'(ovf), 64'd1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("ovf_clr", 64'(ovf), 64'd0);

      // Block completes on the same edge that pops a full FIFO.
      for (int k = 1; k <= 4; k++) send_block(SW'(k));
      chk("pf_full", 64'(fill), 64'd4);
      for (int i = 0; i < 7; i++) send(SW'(5), 1'b0);
      out_ready = 1'b1;
      send(SW'(5), 1'b0);
      chk("pf_fill", 64'(fill), 64'd4);
      chk("pf_ovf", 64'(ovf), 64'd0);
      chk("pf_head", 64'(out_sum), 64'd16);
      for (int k = 3; k <= 5; k++) begin
         tick();
         chk($sformatf("pf_pop%0d", k), 64'(out_sum), 64'(8 * k));
      end
      tick();
      out_ready = 1'b0;
      chk("pf_empty", 64'(out_valid), 64'd0);
      chk("pf_hold", 64'(out_sum), 64'd40);

      // clr mid-block discards the partial sum and the same-cycle sample.
      for (int i = 0; i < 3; i++) send(SW'(100), 1'b0);
      clr = 1'b1;
      send(SW'(100), 1'b0);
      clr = 1'b0;
      send_block(SW'(2));
      chk("clr_sum", 64'(out_sum), 64'd16);
      chk("clr_zc", 64'(out_zero_cnt), 64'd0);
      chk("clr_ovf", 64'(ovf), 64'd0);
      chk("clr_fill", 64'(fill), 64'd1);
      pop_one();

      // Async reset with FIFO occupied and a partial block in flight.
      send_block(SW'(3));
      for (int i = 0; i < 3; i++) send(SW'(7), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_sum", 64'(out_sum), 64'd0);
      chk("arst_fill", 64'(fill), 64'd0);
      #3 rst_n = 1'b1;
      tick();
      send_block(SW'(1));
      chk("arst_new_sum", 64'(out_sum), 64'd8);
      chk("arst_new_fill", 64'(fill), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
